// File: rtl/load_store_unit_pkg.sv
// Shared types, constants and request helpers for the load/store unit.
package lsu_pkg;

   localparam int LSU_XLEN   = 32;
   localparam int LSU_ADDR_W = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      WB   = 3'd4
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Legal width code for the access type and naturally aligned for that width.
   function automatic logic req_ok(input logic st, input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~st;
         F3_HU:   ok = ~st & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables for a store of the given width at byte offset off.
   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] m;
      case (f3)
         F3_B:    m = 4'b0001 << off;
         F3_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Store data replicated across lanes so the mask alone selects the target bytes.
   function automatic logic [LSU_XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [LSU_XLEN-1:0] sd);
      logic [LSU_XLEN-1:0] d;
      case (f3)
         F3_B:    d = {4{sd[7:0]}};
         F3_H:    d = {2{sd[15:0]}};
         default: d = sd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface load_store_unit_if;
   import lsu_pkg::*;

   logic                  mem_valid;
   logic                  mem_ready;
   logic                  mem_we;
   logic [LSU_ADDR_W-1:0] mem_addr;
   logic [LSU_XLEN-1:0]   mem_wdata;
   logic [3:0]            mem_wmask;
   logic                  mem_rvalid;
   logic [LSU_XLEN-1:0]   mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/load_store_unit_load_format.sv
// Extracts the addressed byte/half from a read word and extends it to full width.
module lsu_load_format
   import lsu_pkg::*;
(
   input  logic [LSU_XLEN-1:0] rdata,
   input  logic [1:0]          off,
   input  logic [2:0]          funct3,
   output logic [LSU_XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by sign or zero extension.
   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_BU:   result = {24'd0, byte_sel};
         F3_HU:   result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory request, load formatting and
// register-file write-back, stalling the core until memory has answered.
//
//   state | meaning
//   IDLE  | no request in flight; checks lsu_req for legality/alignment
//   REQ   | mem_valid high, request fields held until mem_ready
//   WAIT  | load accepted, waiting for mem_rvalid
//   DONE  | store retired (stall low)
//   WB    | load retired, register-file write when rd != 0
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN   = LSU_XLEN,
   parameter int ADDR_W = LSU_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lsu_req,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   store_data,
   input  logic [4:0]        rd,
   load_store_unit_if.master mem,
   output logic [4:0]        waddr,
   output logic [XLEN-1:0]   wdata,
   output logic              reg_wr,
   output logic              stall,
   output logic              lsu_err
);

   state_t          state;
   state_t          state_nx;
   logic            ok;
   logic            accept_req;
   logic            capture;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            st_q;
   logic [XLEN-1:0] load_fmt;

   assign ok         = req_ok(is_store, funct3, addr[1:0]);
   assign accept_req = (state == IDLE) && lsu_req && ok;

   lsu_load_format u_fmt (
      .rdata  (mem.mem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .result (load_fmt)
   );

   // Next-state, stall and write-enable decode.
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      reg_wr   = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (accept_req) begin
               state_nx = REQ;
               stall    = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem.mem_ready) begin
               if (st_q) begin
                  state_nx = DONE;
               end else if (mem.mem_rvalid) begin
                  state_nx = WB;
                  capture  = 1'b1;
               end else begin
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (mem.mem_rvalid) begin
               state_nx = WB;
               capture  = 1'b1;
            end
         end
         DONE: state_nx = IDLE;
         WB: begin
            state_nx = IDLE;
            reg_wr   = (rd_q != 5'd0);
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, captured instruction fields, registered bus request and write-back data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         off_q         <= '0;
         f3_q          <= '0;
         rd_q          <= '0;
         st_q          <= 1'b0;
         mem.mem_valid <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_wmask <= '0;
         waddr         <= '0;
         wdata         <= '0;
         lsu_err       <= 1'b0;
      end else begin
         state   <= state_nx;
         lsu_err <= (state == IDLE) && lsu_req && !ok;
         if (accept_req) begin
            off_q         <= addr[1:0];
            f3_q          <= funct3;
            rd_q          <= rd;
            st_q          <= is_store;
            mem.mem_valid <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem.mem_wdata <= is_store ? store_lanes(funct3, store_data) : '0;
            mem.mem_wmask <= is_store ? store_mask(funct3, addr[1:0]) : 4'b0000;
         end else if ((state == REQ) && mem.mem_ready) begin
            mem.mem_valid <= 1'b0;
         end
         if (capture) begin
            waddr <= rd_q;
            wdata <= load_fmt;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected bus requests, register writes and
// error pulses are queued by the stimulus and consumed by an independent monitor.
module tb_load_store_unit;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } req_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        lsu_req = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        reg_wr;
   logic        stall;
   logic        lsu_err;

   int checks = 0;
   int errors = 0;
   int err_pushed = 0;
   int err_seen = 0;

   req_t exp_req[$];
   wr_t  exp_wr[$];
   int   exp_err[$];

   load_store_unit_if mem ();

   load_store_unit dut (
      .clock      (clock),
      .reset      (reset),
      .lsu_req    (lsu_req),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .rd         (rd),
      .mem        (mem),
      .waddr      (waddr),
      .wdata      (wdata),
      .reg_wr     (reg_wr),
      .stall      (stall),
      .lsu_err    (lsu_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the front of each queue.
   always @(negedge clock) begin
      if (mem.mem_valid) begin
         if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_valid addr=%h", mem.mem_addr);
         end else begin
            chk("req_we", {31'd0, mem.mem_we}, {31'd0, exp_req[0].we});
            chk("req_addr", mem.mem_addr, exp_req[0].addr);
            if (exp_req[0].we) begin
               chk("req_wdata", mem.mem_wdata, exp_req[0].wdata);
               chk("req_mask", {28'd0, mem.mem_wmask}, {28'd0, exp_req[0].mask});
            end
            if (mem.mem_ready) void'(exp_req.pop_front());
         end
      end
      if (reg_wr) begin
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_reg_wr waddr=%0d wdata=%h", waddr, wdata);
         end else begin
            chk("wb_waddr", {27'd0, waddr}, {27'd0, exp_wr[0].a});
            chk("wb_wdata", wdata, exp_wr[0].d);
            void'(exp_wr.pop_front());
         end
      end
      if (lsu_err) begin
         err_seen++;
         chk("lsu_err_expected", {31'd0, exp_err.size() > 0}, 32'd1);
         if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
   end

   // One instruction with a simple memory model: ready after rdly wait cycles,
   // read data vdly cycles after acceptance (0 = same cycle as ready).
   task automatic run_op(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                         input bit legal, input logic [3:0] e_mask, input logic [31:0] e_wd,
                         input logic [31:0] rdat, input logic [31:0] e_rd,
                         input int rdly, input int vdly,
                         input int e_stall, input int e_valid, input int e_wr);
      int sc = 0, vc = 0, wc = 0, rc = 0, lc = 0;
      bit acc = 0, got = 0, retired = 0;
      if (legal) begin
         exp_req.push_back(req_t'{we: st, addr: {a[31:2], 2'b00}, wdata: e_wd, mask: e_mask});
         if (!st && r != 5'd0) exp_wr.push_back(wr_t'{a: r, d: e_rd});
      end else begin
         exp_err.push_back(1);
         err_pushed++;
      end
      @(posedge clock); #1;
      lsu_req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (stall) sc++;
         if (mem.mem_valid) vc++;
         if (reg_wr) wc++;
         if (!stall) retired = 1;
         @(posedge clock); #1;
         mem.mem_ready = 1'b0;
         mem.mem_rvalid = 1'b0;
         if (retired) begin
            lsu_req = 1'b0;
            break;
         end
         if (mem.mem_valid) begin
            rc++;
            if (rc > rdly) begin
               mem.mem_ready = 1'b1;
               acc = 1;
               if (!st && vdly == 0) begin
                  mem.mem_rvalid = 1'b1; mem.mem_rdata = rdat; got = 1;
               end
            end
         end else if (acc && !st && !got) begin
            lc++;
            if (lc >= vdly) begin
               mem.mem_rvalid = 1'b1; mem.mem_rdata = rdat; got = 1;
            end
         end
      end
      chk({nm, "_retired"}, {31'd0, retired}, 32'd1);
      chk({nm, "_stall_cycles"}, sc, e_stall);
      chk({nm, "_valid_cycles"}, vc, e_valid);
      chk({nm, "_reg_wr_pulses"}, wc, e_wr);
      repeat (2) @(posedge clock);
   endtask

   initial begin
      mem.mem_ready = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_mem_valid", {31'd0, mem.mem_valid}, 32'd0);
      chk("rst_mem_addr", mem.mem_addr, 32'd0);
      chk("rst_mem_wmask", {28'd0, mem.mem_wmask}, 32'd0);
      chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_lsu_err", {31'd0, lsu_err}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      //     name       st  f3      addr          sd            rd  legal mask     e_wd          rdata         e_rd         rdly vdly stall valid wr
      run_op("lw_basic", 0, 3'b010, 32'h100, 32'h0,         5'd5,  1, 4'h0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 2, 1, 1);
      run_op("lb_neg",   0, 3'b000, 32'h103, 32'h0,         5'd3,  1, 4'h0, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 0, 1, 3, 1, 1);
      run_op("lbu",      0, 3'b100, 32'h103, 32'h0,         5'd4,  1, 4'h0, 32'h0,        32'h80FF1234, 32'h00000080, 0, 0, 2, 1, 1);
      run_op("lh_hi",    0, 3'b001, 32'h102, 32'h0,         5'd6,  1, 4'h0, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 0, 0, 2, 1, 1);
      run_op("lhu_lo",   0, 3'b101, 32'h100, 32'h0,         5'd8,  1, 4'h0, 32'h0,        32'h80FF1234, 32'h00001234, 0, 0, 2, 1, 1);
      run_op("lb_pos",   0, 3'b000, 32'h101, 32'h0,         5'd10, 1, 4'h0, 32'h0,        32'h80FF1234, 32'h00000012, 0, 0, 2, 1, 1);
      run_op("lw_slow",  0, 3'b010, 32'h104, 32'h0,         5'd9,  1, 4'h0, 32'h0,        32'h01234567, 32'h01234567, 1, 2, 5, 2, 1);
      run_op("sh_wait",  1, 3'b001, 32'h202, 32'h0000ABCD,  5'd0,  1, 4'hC, 32'hABCDABCD, 32'h0,        32'h0,        3, 0, 5, 4, 0);
      run_op("sb_lane1", 1, 3'b000, 32'h301, 32'h12345678,  5'd7,  1, 4'h2, 32'h78787878, 32'h0,        32'h0,        0, 0, 2, 1, 0);
      run_op("sw",       1, 3'b010, 32'h400, 32'hCAFEF00D,  5'd7,  1, 4'hF, 32'hCAFEF00D, 32'h0,        32'h0,        0, 0, 2, 1, 0);
      run_op("lw_rd0",   0, 3'b010, 32'h108, 32'h0,         5'd0,  1, 4'h0, 32'h0,        32'h55AA55AA, 32'h0,        0, 0, 2, 1, 0);
      run_op("lw_mis",   0, 3'b010, 32'h101, 32'h0,         5'd5,  0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
      run_op("sb_f3bad", 1, 3'b100, 32'h300, 32'h11,        5'd5,  0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
      run_op("lh_mis",   0, 3'b001, 32'h103, 32'h0,         5'd5,  0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
      run_op("ld_f3bad", 0, 3'b011, 32'h100, 32'h0,         5'd5,  0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);
      run_op("sh_mis",   1, 3'b001, 32'h201, 32'h22,        5'd5,  0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0);

      // Reset while a load waits for its response; the late response must be ignored.
      exp_req.push_back(req_t'{we: 1'b0, addr: 32'h500, wdata: 32'h0, mask: 4'h0});
      @(posedge clock); #1;
      lsu_req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; rd = 5'd7;
      @(posedge clock); #1;
      mem.mem_ready = 1'b1;
      @(posedge clock); #1;
      mem.mem_ready = 1'b0;
      @(negedge clock);
      chk("rst6_in_wait_stall", {31'd0, stall}, 32'd1);
      chk("rst6_in_wait_valid", {31'd0, mem.mem_valid}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      lsu_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata = 32'h11111111;
      @(negedge clock);
      chk("rst6_reg_wr", {31'd0, reg_wr}, 32'd0);
      chk("rst6_stall", {31'd0, stall}, 32'd0);
      chk("rst6_mem_valid", {31'd0, mem.mem_valid}, 32'd0);
      chk("rst6_mem_addr", mem.mem_addr, 32'd0);
      chk("rst6_mem_wdata", mem.mem_wdata, 32'd0);
      chk("rst6_waddr", {27'd0, waddr}, 32'd0);
      chk("rst6_wdata", wdata, 32'd0);
      @(posedge clock); #1;
      mem.mem_rvalid = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst6_reg_wr_after", {31'd0, reg_wr}, 32'd0);
      chk("rst6_stall_after", {31'd0, stall}, 32'd0);
      chk("rst6_waddr_after", {27'd0, waddr}, 32'd0);

      repeat (3) @(posedge clock);
      chk("pending_requests", exp_req.size(), 32'd0);
      chk("pending_writes", exp_wr.size(), 32'd0);
      chk("pending_errors", exp_err.size(), 32'd0);
      chk("error_pulse_total", err_seen, err_pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
